// File: rtl/enc_formatter_ctrl.sv
// rtl/enc_formatter_ctrl.sv - residue-buffer sequencer serving variable-size symbol requests from fixed encoder words
// Optional residue flush port enabled by defining ENC_FMT_FLUSH_EN.

module enc_formatter #(
    localparam int N  = 8,
    localparam int W  = 8,
    localparam int CW = $clog2(N + 1),
    localparam int OW = $clog2(2 * N - 1)
) (
    input  logic [2*N*W-1:0] buf_data,
    input  logic [OW-1:0]    for_offset,
    input  logic [CW-1:0]    for_request,
    output logic [N*W-1:0]   for_data
);

    // Output symbol i comes from buf_data symbol offset+i; unrequested symbols stay 0.
    always_comb begin
        for_data = '0;
        for (int i = 0; i < N; i++) begin
            if (i < int'(for_request) && (int'(for_offset) + i) < 2 * N) begin
                for_data[i*W +: W] = buf_data[(int'(for_offset) + i)*W +: W];
            end
        end
    end

endmodule

module enc_formatter_ctrl #(
    localparam int N  = 8,
    localparam int W  = 8,
    localparam int CW = $clog2(N + 1),
    localparam int LW = $clog2(N),
    localparam int OW = $clog2(2 * N - 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enc_valid,
    output logic            enc_ready,
    input  logic [N*W-1:0]  enc_data,
    input  logic            req_valid,
    input  logic [CW-1:0]   req_count,
    output logic            req_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*W-1:0]  out_data,
    output logic [CW-1:0]   out_count,
    output logic [LW-1:0]   level
`ifdef ENC_FMT_FLUSH_EN
    ,
    input  logic            flush
`endif
);

    logic [N*W-1:0]   res_q;
    logic [LW-1:0]    level_q;
    logic [2*N*W-1:0] buf_data;
    logic [N*W-1:0]   for_data;
    logic [N*W-1:0]   res_src;
    logic [N*W-1:0]   res_nxt;
    logic [LW-1:0]    level_nxt;
    logic [OW-1:0]    for_offset;
    logic [CW-1:0]    for_request;
    logic             stage_free;
    logic             req_legal;
    logic             fire_buf;
    logic             fire_enc;
    logic             fire_flush;
    logic             fire;

    // The incoming word sits just below the residue, so one window covers both sources.
    assign buf_data = {res_q, enc_data};

    enc_formatter u_formatter (
        .buf_data    (buf_data),
        .for_offset  (for_offset),
        .for_request (for_request),
        .for_data    (for_data)
    );

    always_comb begin
        stage_free = rst_n && (!out_valid || out_ready);
        req_legal  = (req_count != '0) && (req_count <= CW'(N));
        fire_buf   = stage_free && req_valid && req_legal && (CW'(level_q) >= req_count);
        fire_enc   = stage_free && req_valid && req_legal && (CW'(level_q) < req_count) && enc_valid;
`ifdef ENC_FMT_FLUSH_EN
        fire_flush = flush && stage_free && (level_q != '0) && !fire_buf && !fire_enc;
`else
        fire_flush = 1'b0;
`endif
        fire        = fire_buf || fire_enc || fire_flush;
        for_request = '0;
        for_offset  = '0;
        level_nxt   = level_q;
        if (fire_buf || fire_enc) begin
            for_request = req_count;
            for_offset  = OW'(N) + OW'(level_q) - OW'(req_count);
            level_nxt   = fire_enc ? LW'(CW'(N) + CW'(level_q) - req_count)
                                   : LW'(CW'(level_q) - req_count);
        end else if (fire_flush) begin
            for_request = CW'(level_q);
            for_offset  = OW'(N);
            level_nxt   = '0;
        end
        // New residue is the youngest level_nxt symbols of its source; everything above is cleared.
        res_src = fire_enc ? enc_data : res_q;
        res_nxt = '0;
        for (int i = 0; i < N; i++) begin
            if (i < int'(level_nxt)) begin
                res_nxt[i*W +: W] = res_src[i*W +: W];
            end
        end
        enc_ready = fire_enc;
        req_ready = fire_buf || fire_enc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q     <= '0;
            level_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            res_q   <= res_nxt;
            level_q <= level_nxt;
            if (fire) begin
                out_valid <= 1'b1;
                out_data  <= for_data;
                out_count <= for_request;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign level = level_q;

endmodule

// File: tb/tb_enc_formatter_ctrl.sv
// tb/tb_enc_formatter_ctrl.sv - self-checking bench for enc_formatter_ctrl against a symbol-queue model

module tb_enc_formatter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enc_valid = 1'b0;
    logic        enc_ready;
    logic [63:0] enc_data = '0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_count = '0;
    logic        req_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [3:0]  out_count;
    logic [2:0]  level;
`ifdef ENC_FMT_FLUSH_EN
    logic        flush = 1'b0;
`endif

    enc_formatter_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enc_valid (enc_valid),
        .enc_ready (enc_ready),
        .enc_data  (enc_data),
        .req_valid (req_valid),
        .req_count (req_count),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .level     (level)
`ifdef ENC_FMT_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [7:0]  q[$];
    logic        m_ov = 1'b0;
    logic [63:0] m_od = '0;
    logic [3:0]  m_oc = '0;

    localparam logic [63:0] WORD_A = 64'hA7A6A5A4A3A2A1A0;
    localparam logic [63:0] WORD_B = 64'hB7B6B5B4B3B2B1B0;
    localparam logic [63:0] WORD_C = 64'hC7C6C5C4C3C2C1C0;
    localparam logic [63:0] WORD_D = 64'hD7D6D5D4D3D2D1D0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: predict handshakes from queue occupancy, then pop the served symbols oldest first.
    task automatic step();
        int r;
        int n;
        bit sf;
        bit legal;
        bit f_req;
        bit f_enc;
        bit f_flush;
        #2;
        r       = int'(req_count);
        sf      = !m_ov || out_ready;
        legal   = (r >= 1) && (r <= 8);
        f_req   = 1'b0;
        f_enc   = 1'b0;
        f_flush = 1'b0;
        if (sf && req_valid && legal && (q.size() >= r || enc_valid)) begin
            f_req = 1'b1;
            f_enc = (q.size() < r);
        end
`ifdef ENC_FMT_FLUSH_EN
        else if (flush && sf && q.size() > 0) begin
            f_flush = 1'b1;
        end
`endif
        check("req_ready", {63'b0, req_ready}, {63'b0, f_req});
        check("enc_ready", {63'b0, enc_ready}, {63'b0, f_enc});
        @(posedge clk);
        #1;
        if (f_enc) begin
            for (int k = 7; k >= 0; k--) q.push_back(enc_data[k*8 +: 8]);
        end
        if (f_req || f_flush) begin
            n    = f_flush ? q.size() : r;
            m_od = '0;
            for (int k = 0; k < n; k++) m_od = (m_od << 8) | 64'(q.pop_front());
            m_oc = 4'(n);
            m_ov = 1'b1;
        end else if (sf) begin
            m_ov = 1'b0;
        end
        check("out_valid", {63'b0, out_valid}, {63'b0, m_ov});
        if (m_ov) begin
            check("out_data", out_data, m_od);
            check("out_count", {60'b0, out_count}, {60'b0, m_oc});
        end
        check("level", {61'b0, level}, 64'(q.size()));
    endtask

    initial begin
        @(posedge clk);
        #1;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_level", {61'b0, level}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_count", {60'b0, out_count}, 64'd0);
        rst_n = 1'b1;

        out_ready = 1'b1;
        req_valid = 1'b1;
        enc_valid = 1'b1;
        req_count = 4'd5;
        enc_data  = WORD_A;
        step();
        check("t2_data", out_data, 64'hA7A6A5A4A3);
        check("t2_level", {61'b0, level}, 64'd3);

        req_count = 4'd3;
        enc_data  = WORD_B;
        step();
        check("t3_data", out_data, 64'hA2A1A0);
        check("t3_level", {61'b0, level}, 64'd0);

        req_count = 4'd6;
        step();
        check("b_data", out_data, 64'hB7B6B5B4B3B2);

        req_count = 4'd8;
        enc_data  = WORD_C;
        step();
        check("t4_data", out_data, 64'hB1B0C7C6C5C4C3C2);
        check("t4_level", {61'b0, level}, 64'd2);

        out_ready = 1'b0;
        req_count = 4'd4;
        enc_data  = WORD_D;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_hold", out_data, 64'hB1B0C7C6C5C4C3C2);
        end
        out_ready = 1'b1;
        step();
        check("t5_resume", out_data, 64'hC1C0D7D6);
        check("t5_level", {61'b0, level}, 64'd6);

        req_count = 4'd1;
        step();
        check("t1_pre_level", {61'b0, level}, 64'd5);
        rst_n = 1'b0;
        #1;
        check("t1_level", {61'b0, level}, 64'd0);
        check("t1_out_valid", {63'b0, out_valid}, 64'd0);
        check("t1_out_data", out_data, 64'd0);
        check("t1_enc_ready", {63'b0, enc_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        m_ov = 1'b0;

`ifdef ENC_FMT_FLUSH_EN
        req_count = 4'd5;
        enc_data  = WORD_A;
        step();
        req_count = 4'd8;
        enc_valid = 1'b0;
        flush     = 1'b1;
        step();
        check("t6_count", {60'b0, out_count}, 64'd3);
        check("t6_level", {61'b0, level}, 64'd0);
        check("t6_data", out_data, 64'hA2A1A0);
        flush = 1'b0;
`endif

        enc_valid = 1'b1;
        req_count = 4'd0;
        step();
        req_count = 4'd9;
        step();

        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_count = ($urandom_range(0, 19) == 0) ? 4'(9 + $urandom_range(0, 1) * 6)
                                                     : 4'($urandom_range(1, 8));
            if ($urandom_range(0, 29) == 0) req_count = 4'd0;
            enc_valid = ($urandom_range(0, 2) != 0);
            enc_data  = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 4) != 0);
`ifdef ENC_FMT_FLUSH_EN
            flush = ($urandom_range(0, 9) == 0);
`endif
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
